// File: rtl/rf_pkg.sv
// Shared widths and arbiter state encoding for the register-file write arbiter.
package rf_pkg;

    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;

    // Which requester wins when both are valid in the same cycle.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_state_e;

endpackage : rf_pkg

// File: rtl/rr_arb2.sv
// Two-requester arbiter: a lone requester always wins, contention goes to the
// favoured side, and each grant hands priority to the other requester.
module rr_arb2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic stall,
    output logic grant0,
    output logic grant1
);

    pri_state_e state_q;
    pri_state_e state_d;

    // Priority state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRI0;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant selection and priority hand-off; nothing is granted during stall or reset.
    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        state_d = state_q;
        if (!stall && !rst) begin
            case (state_q)
                PRI0: begin
                    if (valid0) begin
                        grant0 = 1'b1;
                    end else if (valid1) begin
                        grant1 = 1'b1;
                    end
                end
                PRI1: begin
                    if (valid1) begin
                        grant1 = 1'b1;
                    end else if (valid0) begin
                        grant0 = 1'b1;
                    end
                end
                default: begin
                    grant0 = 1'b0;
                    grant1 = 1'b0;
                end
            endcase
        end
        if (grant0) begin
            state_d = PRI1;
        end else if (grant1) begin
            state_d = PRI0;
        end
    end

endmodule : rr_arb2

// File: rtl/regfile_write_arb.sv
// Register-file write-port arbiter between ALU (req0) and load (req1) writeback.
// Optional feature macro: RF_BYPASS_EN adds a combinational read bypass off the
// registered write port.
module regfile_write_arb
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_dataIn,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt
`ifdef RF_BYPASS_EN
    ,
    output logic                  byp_a_hit,
    output logic                  byp_b_hit,
    output logic [DATA_WIDTH-1:0] byp_data
`endif
);

    logic                  grant0;
    logic                  grant1;
    logic                  rf_we_q;
    logic                  rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_rd_q;
    logic [ADDR_WIDTH-1:0] rf_rd_d;
    logic [DATA_WIDTH-1:0] rf_data_q;
    logic [DATA_WIDTH-1:0] rf_data_d;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .stall  (stall),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Capture the granted request; writes to r0 are accepted but never strobed.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        if (grant0) begin
            if (req0_addr != '0) begin
                rf_we_d   = 1'b1;
                rf_rd_d   = req0_addr;
                rf_data_d = req0_data;
            end
        end else if (grant1) begin
            if (req1_addr != '0) begin
                rf_we_d   = 1'b1;
                rf_rd_d   = req1_addr;
                rf_data_d = req1_data;
            end
        end
    end

    // Register-file write port drive, one cycle after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_rd     = rf_rd_q;
    assign rf_dataIn = rf_data_q;

`ifdef RF_BYPASS_EN
    // Forward the in-flight write to readers of the same non-zero register.
    always_comb begin
        byp_a_hit = rf_we_q && (rf_rd_q == rs) && (rs != '0);
        byp_b_hit = rf_we_q && (rf_rd_q == rt) && (rt != '0);
        byp_data  = rf_data_q;
    end
`else
    logic unused_read_addrs;
    assign unused_read_addrs = ^{rs, rt};
`endif

endmodule : regfile_write_arb

// File: tb/tb_regfile_write_arb.sv
// Scoreboard bench for regfile_write_arb: directed scenarios then random traffic.
module tb_regfile_write_arb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          rf_we;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_dataIn;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
`ifdef RF_BYPASS_EN
    logic          byp_a_hit;
    logic          byp_b_hit;
    logic [DW-1:0] byp_data;
`endif

    regfile_write_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_dataIn  (rf_dataIn),
        .rs         (rs),
        .rt         (rt)
`ifdef RF_BYPASS_EN
        ,
        .byp_a_hit  (byp_a_hit),
        .byp_b_hit  (byp_b_hit),
        .byp_data   (byp_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Requester-side view: a pending request stays offered until accepted.
    bit            p0v, p1v, stall_v;
    logic [AW-1:0] p0a, p1a, rs_v, rt_v;
    logic [DW-1:0] p0d, p1d;
    int            last_grant = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        stall      = stall_v;
        req0_valid = p0v;
        req0_addr  = p0a;
        req0_data  = p0d;
        req1_valid = p1v;
        req1_addr  = p1a;
        req1_data  = p1d;
        rs         = rs_v;
        rt         = rt_v;
    endtask

    // One cycle: drive, predict the grant, check readies, queue the expected write.
    task automatic step();
        exp_t e;
        bit   g0, g1;
        int   fav;
        apply();
        #2;
        fav = 1 - last_grant;
        g0  = !stall_v && p0v && (!p1v || fav == 0);
        g1  = !stall_v && p1v && !g0;
        check("req0_ready", 64'(req0_ready), 64'(g0));
        check("req1_ready", 64'(req1_ready), 64'(g1));
        e.we   = 1'b0;
        e.addr = '0;
        e.data = '0;
        if (g0) begin
            e.we = (p0a != '0); e.addr = p0a; e.data = p0d;
            last_grant = 0; p0v = 1'b0;
        end else if (g1) begin
            e.we = (p1a != '0); e.addr = p1a; e.data = p1d;
            last_grant = 1; p1v = 1'b0;
        end
        sbq.push_back(e);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse landing in the middle of an offered transfer.
    task automatic reset_pulse();
        apply();
        #1 rst = 1'b1;
        #1;
        check("rst_rf_we", 64'(rf_we), 64'(0));
        check("rst_rf_rd", 64'(rf_rd), 64'(0));
        check("rst_rf_data", 64'(rf_dataIn), 64'(0));
        check("rst_ready0", 64'(req0_ready), 64'(0));
        check("rst_ready1", 64'(req1_ready), 64'(0));
`ifdef RF_BYPASS_EN
        check("rst_byp_a", 64'(byp_a_hit), 64'(0));
        check("rst_byp_b", 64'(byp_b_hit), 64'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        last_grant = 1;
    endtask

    // Monitor: every cycle compare the write port (and bypass) against the queue head.
    initial begin
        exp_t e;
        bit   ea, eb;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
            end else begin
                e.we = 1'b0; e.addr = '0; e.data = '0;
            end
            check("rf_we", 64'(rf_we), 64'(e.we));
            if (e.we) begin
                check("rf_rd", 64'(rf_rd), 64'(e.addr));
                check("rf_dataIn", 64'(rf_dataIn), 64'(e.data));
            end
`ifdef RF_BYPASS_EN
            ea = e.we && (e.addr == rs_v) && (rs_v != '0);
            eb = e.we && (e.addr == rt_v) && (rt_v != '0);
            check("byp_a_hit", 64'(byp_a_hit), 64'(ea));
            check("byp_b_hit", 64'(byp_b_hit), 64'(eb));
            if (e.we) check("byp_data", 64'(byp_data), 64'(e.data));
`else
            ea = 1'b0; eb = ea;
`endif
        end
    end

    initial begin
        logic [AW-1:0] recent;
        p0v = 0; p1v = 0; stall_v = 0;
        p0a = '0; p1a = '0; p0d = '0; p1d = '0; rs_v = '0; rt_v = '0;
        recent = '0;
        rst = 1'b1;
        apply();
        repeat (3) @(negedge clk);
        check("init_rf_we", 64'(rf_we), 64'(0));
        check("init_rf_rd", 64'(rf_rd), 64'(0));
        check("init_ready0", 64'(req0_ready), 64'(0));
        rst = 1'b0;

        // Single request from the ALU port.
        p0v = 1; p0a = 5'd1; p0d = 32'd2001;
        step();
        step();

        // Contention straight after reset, with bypass readers on 6 and 8.
        reset_pulse();
        rs_v = 5'd6; rt_v = 5'd8;
        p0v = 1; p0a = 5'd2; p0d = 32'd4001;
        p1v = 1; p1a = 5'd6; p1d = 32'd5001;
        step();
        step();
        step();

        // Both requesters continuously valid: grants must alternate.
        for (int i = 0; i < 6; i++) begin
            if (!p0v) begin p0v = 1; p0a = AW'(i + 9);  p0d = 32'(1000 + i); end
            if (!p1v) begin p1v = 1; p1a = AW'(i + 17); p1d = 32'(3000 + i); end
            step();
        end
        while (p0v || p1v) step();

        // r0 write is accepted but dropped; then req1 to r8 against a pending req0.
        rs_v = '0;
        p1v = 1; p1a = '0; p1d = 32'd3001;
        step();
        p1v = 1; p1a = 5'd8; p1d = 32'd3001;
        p0v = 1; p0a = 5'd6; p0d = 32'd5001;
        step();
        step();

        // Stall holds off an offered request for three cycles.
        stall_v = 1; p0v = 1; p0a = 5'd3; p0d = 32'd77;
        repeat (3) step();
        stall_v = 0;
        step();
        step();

        // Reset in the middle of an offered transfer.
        p0v = 1; p0a = 5'd4; p0d = 32'd99;
        step();
        p1v = 1; p1a = 5'd5; p1d = 32'd123;
        reset_pulse();
        step();
        step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            stall_v = ($urandom % 6 == 0);
            if (!p0v && ($urandom % 3 != 0)) begin
                p0v = 1; p0a = AW'($urandom); p0d = $urandom;
            end
            if (!p1v && ($urandom % 3 != 0)) begin
                p1v = 1; p1a = AW'($urandom); p1d = $urandom;
            end
            rs_v = ($urandom % 2 == 0) ? recent : AW'($urandom);
            rt_v = ($urandom % 2 == 0) ? recent : AW'($urandom);
            recent = ($urandom % 2 == 0) ? p0a : p1a;
            if ($urandom % 60 == 0) reset_pulse();
            else step();
        end

        p0v = 0; p1v = 0; stall_v = 0;
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_write_arb
